// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared state type, default geometry and width helper for the system-bus arbiter
package sys_bus_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  localparam int DEF_NM = 2;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int DEF_TIMEOUT = 255;
  localparam int BE_W = DEF_DW / 8;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/sys_bus_if.sv
// sys_bus_if: packed master request channels plus the single shared slave port
interface sys_bus_if
  import sys_bus_pkg::*;
#(
  parameter int NM = DEF_NM,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  localparam int BW = DW / 8;
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_we;
  logic [NM*BW-1:0] m_be;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_ack;
  logic [NM-1:0]    m_err;
  logic [DW-1:0]    m_rdata;
  logic             s_req;
  logic             s_we;
  logic [BW-1:0]    s_be;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic             s_ack;
  logic [DW-1:0]    s_rdata;
  modport master (
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_ack, m_err, m_rdata
  );
  modport slave (
    input  s_req, s_we, s_be, s_addr, s_wdata,
    output s_ack, s_rdata
  );
  modport arb (
    input  m_req, m_we, m_be, m_addr, m_wdata, s_ack, s_rdata,
    output m_ack, m_err, m_rdata, s_req, s_we, s_be, s_addr, s_wdata
  );
endinterface

// File: rtl/sys_bus_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 with wrap
module rr_arbiter
  import sys_bus_pkg::*;
#(
  parameter  int NM = DEF_NM,
  localparam int IW = clog2(NM)
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] last_i,
  output logic [NM-1:0] gnt_o,
  output logic [IW-1:0] idx_o
);
  // walk candidates farthest-first so the nearest requester after last wins
  always_comb begin
    logic [IW-1:0] c;
    c = '0;
    idx_o = '0;
    for (int i = NM; i >= 1; i--) begin
      c = IW'((int'(last_i) + i) % NM);
      if (req_i[c]) idx_o = c;
    end
    gnt_o = (|req_i) ? (NM'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/sys_bus.sv
// sys_bus: round-robin multi-master arbiter with registered slave port and timeout completion
module sys_bus
  import sys_bus_pkg::*;
#(
  parameter int NM      = DEF_NM,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic   clk,
  input logic   rst,
  sys_bus_if.arb bus
);
  localparam int BW = DW / 8;
  localparam int IW = clog2(NM);
  localparam int CW = clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          s_req_q, s_req_d, s_we_q, s_we_d;
  logic [BW-1:0] s_be_q, s_be_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d, m_rdata_q, m_rdata_d;
  logic [NM-1:0] m_ack_q, m_ack_d, m_err_q, m_err_d, req, gnt;
  assign req = bus.m_req & ~m_ack_q;
  rr_arbiter #(.NM(NM)) u_arb (
    .req_i (req),
    .last_i(last_q),
    .gnt_o (gnt),
    .idx_o (idx)
  );
  assign bus.s_req   = s_req_q;
  assign bus.s_we    = s_we_q;
  assign bus.s_be    = s_be_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_wdata = s_wdata_q;
  assign bus.m_ack   = m_ack_q;
  assign bus.m_err   = m_err_q;
  assign bus.m_rdata = m_rdata_q;
  // state and datapath registers; reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IW'(NM - 1);
      cnt_q     <= '0;
      err_q     <= 1'b0;
      s_req_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_be_q    <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      m_ack_q   <= '0;
      m_err_q   <= '0;
      m_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      s_be_q    <= s_be_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
    end
  end
  // next state: latch the winner in IDLE, wait for ack or timeout in BUSY, complete in DONE
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    s_req_d   = s_req_q;
    s_we_d    = s_we_q;
    s_be_d    = s_be_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    m_ack_d   = '0;
    m_err_d   = '0;
    m_rdata_d = m_rdata_q;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d   = BUSY;
        grant_d   = idx;
        s_req_d   = 1'b1;
        s_we_d    = bus.m_we[idx];
        s_be_d    = bus.m_be[idx*BW +: BW];
        s_addr_d  = bus.m_addr[idx*AW +: AW];
        s_wdata_d = bus.m_wdata[idx*DW +: DW];
      end
      BUSY: begin
        cnt_d = (cnt_q == TO) ? cnt_q : cnt_q + 1'b1;
        if (bus.s_ack) begin
          m_rdata_d = bus.s_rdata;
          last_d    = grant_q;
          s_req_d   = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == TO) begin
          err_d   = 1'b1;
          last_d  = grant_q;
          s_req_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        m_ack_d = NM'(1) << grant_q;
        m_err_d = err_q ? (NM'(1) << grant_q) : '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sys_bus.sv
// tb_sys_bus: directed self-checking bench for the two-master arbiter with a short timeout
module tb_sys_bus;
  import sys_bus_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  sys_bus_if #(.NM(2), .AW(32), .DW(32)) bus ();
  sys_bus #(.NM(2), .AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_s_req"}, bus.s_req, 0);
    chk({tag, "_s_we"}, bus.s_we, 0);
    chk({tag, "_s_be"}, bus.s_be, 0);
    chk({tag, "_s_addr"}, bus.s_addr, 0);
    chk({tag, "_s_wdata"}, bus.s_wdata, 0);
    chk({tag, "_m_ack"}, bus.m_ack, 0);
    chk({tag, "_m_err"}, bus.m_err, 0);
    chk({tag, "_m_rdata"}, bus.m_rdata, 0);
  endtask
  task automatic set_m(input int i, input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    bus.m_we[i] = we;
    bus.m_be[i*BE_W +: BE_W] = be;
    bus.m_addr[i*32 +: 32] = addr;
    bus.m_wdata[i*32 +: 32] = wd;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired before the directed sequence ended");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0]  exp_ack;
    logic [31:0] exp_addr;
    bus.m_req = '0;
    bus.m_we = '0;
    bus.m_be = '0;
    bus.m_addr = '0;
    bus.m_wdata = '0;
    bus.s_ack = 1'b0;
    bus.s_rdata = '0;
    tick;
    tick;
    chk_zero("reset");
    rst = 1'b1;
    tick;
    set_m(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    bus.m_req = 2'b01;
    tick;
    chk("rd_s_req", bus.s_req, 1);
    chk("rd_s_addr", bus.s_addr, 32'h10);
    chk("rd_s_we", bus.s_we, 0);
    chk("rd_s_be", bus.s_be, 4'hF);
    tick;
    chk("rd_wait_s_req", bus.s_req, 1);
    bus.s_ack = 1'b1;
    bus.s_rdata = 32'hDEAD_BEEF;
    tick;
    bus.s_ack = 1'b0;
    bus.s_rdata = '0;
    chk("rd_done_s_req", bus.s_req, 0);
    chk("rd_done_m_ack", bus.m_ack, 0);
    tick;
    chk("rd_m_ack", bus.m_ack, 2'b01);
    chk("rd_m_err", bus.m_err, 0);
    chk("rd_m_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    bus.m_req = 2'b00;
    tick;
    chk("rd_ack_one_cycle", bus.m_ack, 0);
    set_m(1, 1'b1, 4'b0001, 32'h0000_0020, 32'h0000_00AA);
    bus.m_req = 2'b10;
    tick;
    chk("wr_s_req", bus.s_req, 1);
    chk("wr_s_we", bus.s_we, 1);
    chk("wr_s_be", bus.s_be, 4'b0001);
    chk("wr_s_addr", bus.s_addr, 32'h20);
    chk("wr_s_wdata", bus.s_wdata, 32'hAA);
    bus.m_addr[32 +: 32] = 32'h99;
    bus.m_be[4 +: 4] = 4'hF;
    tick;
    tick;
    chk("wr_hold_addr", bus.s_addr, 32'h20);
    chk("wr_hold_be", bus.s_be, 4'b0001);
    chk("wr_hold_req", bus.s_req, 1);
    bus.s_ack = 1'b1;
    tick;
    bus.s_ack = 1'b0;
    tick;
    chk("wr_m_ack", bus.m_ack, 2'b10);
    chk("wr_m_err", bus.m_err, 0);
    bus.m_req = 2'b00;
    set_m(0, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
    set_m(1, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
    bus.m_req = 2'b11;
    bus.s_ack = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick;
      exp_ack = (n % 3 == 2) ? (((n / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk($sformatf("rr_m_ack_%0d", n), bus.m_ack, exp_ack);
      if (n % 3 == 0) begin
        exp_addr = ((n / 3) % 2 == 1) ? 32'h200 : 32'h100;
        chk($sformatf("rr_s_addr_%0d", n), bus.s_addr, exp_addr);
      end
    end
    bus.m_req = 2'b00;
    bus.s_ack = 1'b0;
    set_m(0, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
    bus.m_req = 2'b01;
    tick;
    chk("to_s_req_rise", bus.s_req, 1);
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk($sformatf("to_s_req_%0d", k), bus.s_req, k <= 4);
      chk($sformatf("to_m_ack_%0d", k), bus.m_ack, (k == 6) ? 2'b01 : 2'b00);
      chk($sformatf("to_m_err_%0d", k), bus.m_err, (k == 6) ? 2'b01 : 2'b00);
    end
    bus.m_req = 2'b00;
    set_m(1, 1'b0, 4'hF, 32'h0000_0300, 32'h0);
    bus.m_req = 2'b10;
    tick;
    chk("post_to_s_req", bus.s_req, 1);
    chk("post_to_s_addr", bus.s_addr, 32'h300);
    bus.s_ack = 1'b1;
    bus.s_rdata = 32'h1234_5678;
    tick;
    bus.s_ack = 1'b0;
    bus.s_rdata = '0;
    tick;
    chk("post_to_m_ack", bus.m_ack, 2'b10);
    chk("post_to_m_err", bus.m_err, 0);
    chk("post_to_m_rdata", bus.m_rdata, 32'h1234_5678);
    bus.m_req = 2'b00;
    bus.s_ack = 1'b1;
    bus.s_rdata = 32'hFFFF_0000;
    tick;
    tick;
    chk("stray_m_ack", bus.m_ack, 0);
    chk("stray_s_req", bus.s_req, 0);
    chk("stray_m_rdata", bus.m_rdata, 32'h1234_5678);
    bus.s_ack = 1'b0;
    bus.s_rdata = '0;
    bus.m_req = 2'b10;
    tick;
    chk("mid_s_req", bus.s_req, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("rst_mid");
    tick;
    tick;
    chk("rst_no_ack", bus.m_ack, 0);
    bus.m_req = 2'b11;
    rst = 1'b1;
    tick;
    chk("rst_first_s_req", bus.s_req, 1);
    chk("rst_first_s_addr", bus.s_addr, 32'h40);
    bus.s_ack = 1'b1;
    tick;
    bus.s_ack = 1'b0;
    tick;
    chk("rst_first_m_ack", bus.m_ack, 2'b01);
    bus.m_req = 2'b00;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
